// File: rtl/mode_proto_pkg.sv
// Shared protocol constants, queue entry layout and transmit FSM encoding
// for the mode/rate command transmitter.
package mode_proto_pkg;

  // Protocol bytes that frame a rate change
  localparam logic [7:0] MODE_ENTER_U = 8'h4D;
  localparam logic [7:0] MODE_ENTER_L = 8'h6D;
  localparam logic [7:0] MODE_EXIT_U  = 8'h46;
  localparam logic [7:0] MODE_EXIT_L  = 8'h66;
  localparam logic [7:0] RATE_CHR_0   = 8'h31;
  localparam logic [7:0] RATE_CHR_1   = 8'h35;
  localparam logic [7:0] RATE_CHR_2   = 8'h41;

  // Rate codes carried on req_rate
  localparam logic [1:0] RATE_CODE_0 = 2'b00;
  localparam logic [1:0] RATE_CODE_1 = 2'b01;
  localparam logic [1:0] RATE_CODE_2 = 2'b10;

  // Transmit FSM states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_M    = 3'd1,
    SEND_RATE = 3'd2,
    SEND_F    = 3'd3,
    SEND_DATA = 3'd4,
    GAP       = 3'd5
  } tx_state_e;

  // One queued request: 11 bits
  typedef struct packed {
    logic       kind;
    logic [1:0] rate;
    logic [7:0] data;
  } cmd_entry_t;

  // ASCII character sent for a rate code (illegal code maps to 0x00)
  function automatic logic [7:0] rate_to_chr(input logic [1:0] rate);
    logic [7:0] chr;
    case (rate)
      RATE_CODE_0: chr = RATE_CHR_0;
      RATE_CODE_1: chr = RATE_CHR_1;
      RATE_CODE_2: chr = RATE_CHR_2;
      default:     chr = 8'h00;
    endcase
    return chr;
  endfunction

  // A request is refused if it is an unknown rate or a data byte that the
  // receiver would mistake for framing (or a NUL)
  function automatic logic req_is_illegal(input logic       kind,
                                          input logic [1:0] rate,
                                          input logic [7:0] data);
    logic bad;
    if (kind) begin
      bad = (rate == 2'b11);
    end else begin
      bad = (data == 8'h00)        || (data == MODE_ENTER_U) ||
            (data == MODE_ENTER_L) || (data == MODE_EXIT_U)  ||
            (data == MODE_EXIT_L);
    end
    return bad;
  endfunction

endpackage

// File: rtl/mode_cmd_fifo.sv
// Request queue for mode_command_tx: DEPTH entries of cmd_entry_t,
// first-word-fall-through head, pointers wrap modulo DEPTH.
module mode_cmd_fifo
  import mode_proto_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  cmd_entry_t i_push_data,
  input  logic       i_pop,
  output cmd_entry_t o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == (AW+1)'(0));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  // Storage write and pointer/count bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mode_command_tx.sv
// Mode/rate command transmitter: queues byte and rate requests, expands a
// rate request into 'M' <rate> 'F', and paces every byte to the UART with
// GAP_CYCLES idle clocks.
module mode_command_tx
  import mode_proto_pkg::*;
#(
  parameter int GAP_CYCLES = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_kind,
  input  logic [7:0] req_data,
  input  logic [1:0] req_rate,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       err,
  output logic       busy
);

  localparam logic       HAS_GAP  = (GAP_CYCLES > 32'sd0);
  localparam logic [7:0] GAP_LAST = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'h00;

  logic       r_ready_en;
  logic       r_err;
  tx_state_e  r_state;
  tx_state_e  w_state_nxt;
  tx_state_e  r_gap_ret;
  tx_state_e  w_gap_ret_nxt;
  tx_state_e  w_dest;
  logic [7:0] r_gap_cnt;
  logic [7:0] w_gap_cnt_nxt;
  cmd_entry_t r_cur;
  cmd_entry_t w_cur_nxt;
  cmd_entry_t w_head;
  cmd_entry_t w_req_entry;
  logic       r_tx_valid;
  logic [7:0] r_tx_data;
  logic       w_tx_valid_nxt;
  logic [7:0] w_tx_data_nxt;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_go;
  logic       w_byte_done;
  logic       w_req_hs;
  logic       w_req_bad;
  logic       w_push;

  // req_ready is held low until the first edge after reset release
  assign req_ready   = r_ready_en && !w_full;
  assign w_req_hs    = req_valid && req_ready;
  assign w_req_bad   = req_is_illegal(req_kind, req_rate, req_data);
  assign w_push      = w_req_hs && !w_req_bad;
  assign w_req_entry = '{kind: req_kind, rate: req_rate, data: req_data};

  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign err      = r_err;
  assign busy     = (r_state != IDLE) || !w_empty;

  mode_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_req_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Ready enable and one-cycle rejection pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ready_en <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      r_err      <= w_req_hs && w_req_bad;
    end
  end

  // FSM state, gap counter, current request and registered UART outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_gap_ret  <= IDLE;
      r_gap_cnt  <= 8'h00;
      r_cur      <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_gap_ret  <= w_gap_ret_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_cur      <= w_cur_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_data  <= w_tx_data_nxt;
    end
  end

  // Next state: finish a byte or gap, then either pace, advance, or pop the
  // next request straight away so a zero gap gives back-to-back bytes
  always_comb begin
    w_state_nxt   = r_state;
    w_gap_ret_nxt = r_gap_ret;
    w_gap_cnt_nxt = r_gap_cnt;
    w_cur_nxt     = r_cur;
    w_pop         = 1'b0;
    w_go          = 1'b0;
    w_byte_done   = 1'b0;
    w_dest        = IDLE;

    case (r_state)
      IDLE: begin
        w_go   = 1'b1;
        w_dest = IDLE;
      end
      SEND_M: begin
        w_byte_done = tx_ready;
        w_dest      = SEND_RATE;
      end
      SEND_RATE: begin
        w_byte_done = tx_ready;
        w_dest      = SEND_F;
      end
      SEND_F: begin
        w_byte_done = tx_ready;
        w_dest      = IDLE;
      end
      SEND_DATA: begin
        w_byte_done = tx_ready;
        w_dest      = IDLE;
      end
      GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_go   = 1'b1;
          w_dest = r_gap_ret;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 8'h01;
        end
      end
      default: begin
        w_go   = 1'b1;
        w_dest = IDLE;
      end
    endcase

    if (w_byte_done && HAS_GAP) begin
      w_state_nxt   = GAP;
      w_gap_cnt_nxt = 8'h00;
      w_gap_ret_nxt = w_dest;
    end else if (w_byte_done || w_go) begin
      if (w_dest != IDLE) begin
        w_state_nxt = w_dest;
      end else if (!w_empty) begin
        w_pop       = 1'b1;
        w_cur_nxt   = w_head;
        w_state_nxt = w_head.kind ? SEND_M : SEND_DATA;
      end else begin
        w_state_nxt = IDLE;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // UART byte for the state being entered; low/zero outside SEND_* states
  always_comb begin
    w_tx_valid_nxt = 1'b1;
    w_tx_data_nxt  = 8'h00;
    case (w_state_nxt)
      SEND_M:    w_tx_data_nxt = MODE_ENTER_U;
      SEND_RATE: w_tx_data_nxt = rate_to_chr(w_cur_nxt.rate);
      SEND_F:    w_tx_data_nxt = MODE_EXIT_U;
      SEND_DATA: w_tx_data_nxt = w_cur_nxt.data;
      default:   w_tx_valid_nxt = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mode_command_tx.sv
// Directed self-checking bench for mode_command_tx: a vector table of single
// requests on a GAP_CYCLES=16 instance, plus hand sequences for latency,
// back-pressure, mid-sequence reset and a zero-gap instance.
module tb_mode_command_tx;

  localparam int GAP = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       req_valid, req_ready, req_kind, tx_valid, tx_ready, err, busy;
  logic [7:0] req_data, tx_data;
  logic [1:0] req_rate;
  logic       req_valid_z, req_ready_z, req_kind_z, tx_valid_z, tx_ready_z, err_z, busy_z;
  logic [7:0] req_data_z, tx_data_z;
  logic [1:0] req_rate_z;

  mode_command_tx #(.GAP_CYCLES(GAP), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_data(req_data), .req_rate(req_rate),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .err(err), .busy(busy)
  );

  mode_command_tx #(.GAP_CYCLES(0), .FIFO_DEPTH(4)) dut_z (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_kind(req_kind_z),
    .req_data(req_data_z), .req_rate(req_rate_z),
    .tx_data(tx_data_z), .tx_valid(tx_valid_z), .tx_ready(tx_ready_z),
    .err(err_z), .busy(busy_z)
  );

  int cyc = 0;
  int n_pass = 0;
  int n_chk = 0;

  logic [7:0] mon_q[$];
  int         mon_cyc[$];
  int         err_cnt = 0;
  int         err_last = 0;
  logic [7:0] mz_q[$];
  int         mz_cyc[$];

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Record UART handshakes and err pulses away from the active edge
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      mon_q.push_back(tx_data);
      mon_cyc.push_back(cyc);
    end
    if (tx_valid_z && tx_ready_z) begin
      mz_q.push_back(tx_data_z);
      mz_cyc.push_back(cyc);
    end
    if (err) begin
      err_cnt  <= err_cnt + 1;
      err_last <= cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic k, input logic [1:0] r, input logic [7:0] d, output int hs);
    int t;
    t = 0;
    req_valid = 1'b1; req_kind = k; req_rate = r; req_data = d;
    while (!req_ready && t < 50) begin tick(1); t++; end
    if (!req_ready) check("push_ready_timeout", 32'd0, 32'd1);
    hs = cyc;
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic push_z(input logic k, input logic [1:0] r, input logic [7:0] d, output int hs);
    int t;
    t = 0;
    req_valid_z = 1'b1; req_kind_z = k; req_rate_z = r; req_data_z = d;
    while (!req_ready_z && t < 50) begin tick(1); t++; end
    if (!req_ready_z) check("pushz_ready_timeout", 32'd0, 32'd1);
    hs = cyc;
    tick(1);
    req_valid_z = 1'b0;
  endtask

  typedef struct {
    logic       kind;
    logic [1:0] rate;
    logic [7:0] data;
    logic       exp_err;
    int         nbytes;
    logic [7:0] b0, b1, b2;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int hs, hs2, base, ebase, t;
    logic [7:0] eb;

    vecs[0]  = '{1'b0, 2'b00, 8'h41, 1'b0, 1, 8'h41, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 2'b01, 8'h00, 1'b0, 3, 8'h4D, 8'h35, 8'h46};
    vecs[2]  = '{1'b1, 2'b00, 8'h00, 1'b0, 3, 8'h4D, 8'h31, 8'h46};
    vecs[3]  = '{1'b1, 2'b10, 8'h00, 1'b0, 3, 8'h4D, 8'h41, 8'h46};
    vecs[4]  = '{1'b0, 2'b00, 8'h6D, 1'b1, 0, 8'h00, 8'h00, 8'h00};
    vecs[5]  = '{1'b0, 2'b00, 8'h00, 1'b1, 0, 8'h00, 8'h00, 8'h00};
    vecs[6]  = '{1'b1, 2'b11, 8'h00, 1'b1, 0, 8'h00, 8'h00, 8'h00};
    vecs[7]  = '{1'b0, 2'b00, 8'h4D, 1'b1, 0, 8'h00, 8'h00, 8'h00};
    vecs[8]  = '{1'b0, 2'b00, 8'h46, 1'b1, 0, 8'h00, 8'h00, 8'h00};
    vecs[9]  = '{1'b0, 2'b00, 8'h66, 1'b1, 0, 8'h00, 8'h00, 8'h00};
    vecs[10] = '{1'b0, 2'b11, 8'hFF, 1'b0, 1, 8'hFF, 8'h00, 8'h00};
    vecs[11] = '{1'b0, 2'b00, 8'h6E, 1'b0, 1, 8'h6E, 8'h00, 8'h00};

    reset = 1'b0;
    req_valid = 1'b0; req_kind = 1'b0; req_data = 8'h00; req_rate = 2'b00; tx_ready = 1'b1;
    req_valid_z = 1'b0; req_kind_z = 1'b0; req_data_z = 8'h00; req_rate_z = 2'b00; tx_ready_z = 1'b1;

    // Reset state
    tick(3);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_req_ready", req_ready, 1'b0);
    reset = 1'b1;
    check("rel_req_ready_before_edge", req_ready, 1'b0);
    tick(1);
    check("rel_req_ready_first_edge", req_ready, 1'b1);
    tick(2);

    // Table of single requests with tx_ready held high
    for (int i = 0; i < 12; i++) begin
      base  = mon_q.size();
      ebase = err_cnt;
      push_a(vecs[i].kind, vecs[i].rate, vecs[i].data, hs);
      tick(3 * (GAP + 1) + 8);
      check($sformatf("v%0d_nbytes", i), mon_q.size() - base, vecs[i].nbytes);
      check($sformatf("v%0d_errs", i), err_cnt - ebase, {31'd0, vecs[i].exp_err});
      if (vecs[i].exp_err) check($sformatf("v%0d_err_cycle", i), err_last, hs + 1);
      for (int j = 0; j < vecs[i].nbytes; j++) begin
        eb = (j == 0) ? vecs[i].b0 : ((j == 1) ? vecs[i].b1 : vecs[i].b2);
        if (base + j < mon_q.size()) begin
          check($sformatf("v%0d_byte%0d", i, j), mon_q[base + j], eb);
          check($sformatf("v%0d_cyc%0d", i, j), mon_cyc[base + j], hs + 2 + j * (GAP + 1));
        end
      end
      check($sformatf("v%0d_idle_busy", i), busy, 1'b0);
      check($sformatf("v%0d_idle_ready", i), req_ready, 1'b1);
    end

    // Cycle-by-cycle latency and gap for one data byte
    push_a(1'b0, 2'b00, 8'h41, hs);
    while (cyc <= hs + 20) begin
      check($sformatf("lat_valid_c%0d", cyc - hs), tx_valid, (cyc == hs + 2));
      if (cyc == hs + 2) check("lat_data", tx_data, 8'h41);
      check($sformatf("lat_busy_c%0d", cyc - hs), busy, (cyc <= hs + 18));
      tick(1);
    end

    // Back-pressure: five back-to-back pushes with the UART stalled
    tx_ready = 1'b0;
    base = mon_q.size();
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_kind = 1'b0; req_data = 8'h11 + 8'(i);
      check($sformatf("fill_ready%0d", i), req_ready, 1'b1);
      tick(1);
    end
    req_valid = 1'b0;
    check("fill_full", req_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_valid%0d", i), tx_valid, 1'b1);
      check($sformatf("stall_data%0d", i), tx_data, 8'h11);
      tick(1);
    end
    check("stall_no_hs", mon_q.size() - base, 0);
    tx_ready = 1'b1;
    tick(5 * (GAP + 1) + 10);
    check("drain_nbytes", mon_q.size() - base, 5);
    for (int i = 0; i < 5; i++)
      if (base + i < mon_q.size()) check($sformatf("drain_byte%0d", i), mon_q[base + i], 8'h11 + 8'(i));
    check("drain_busy", busy, 1'b0);

    // Reset after the 'M' of a rate command
    base = mon_q.size();
    push_a(1'b1, 2'b10, 8'h00, hs);
    t = 0;
    while (mon_q.size() == base && t < 20) begin tick(1); t++; end
    check("abort_first", mon_q.size() - base, 1);
    if (mon_q.size() > base) check("abort_first_byte", mon_q[base], 8'h4D);
    reset = 1'b0;
    tick(1);
    check("abort_rst_valid", tx_valid, 1'b0);
    check("abort_rst_busy", busy, 1'b0);
    check("abort_rst_ready", req_ready, 1'b0);
    tick(2);
    reset = 1'b1;
    tick(60);
    check("abort_no_more", mon_q.size() - base, 1);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", req_ready, 1'b1);

    // Zero-gap instance: consecutive bytes
    base = mz_q.size();
    push_z(1'b0, 2'b00, 8'h10, hs);
    push_z(1'b0, 2'b00, 8'h20, hs2);
    check("z_back_to_back", hs2, hs + 1);
    tick(10);
    check("z_nbytes", mz_q.size() - base, 2);
    if (mz_q.size() >= base + 2) begin
      check("z_byte0", mz_q[base], 8'h10);
      check("z_byte1", mz_q[base + 1], 8'h20);
      check("z_cyc0", mz_cyc[base], hs + 2);
      check("z_cyc1", mz_cyc[base + 1], hs + 3);
    end
    base = mz_q.size();
    push_z(1'b1, 2'b01, 8'h00, hs);
    tick(10);
    check("zr_nbytes", mz_q.size() - base, 3);
    if (mz_q.size() >= base + 3) begin
      check("zr_byte0", mz_q[base], 8'h4D);
      check("zr_byte1", mz_q[base + 1], 8'h35);
      check("zr_byte2", mz_q[base + 2], 8'h46);
      check("zr_cyc2", mz_cyc[base + 2], hs + 4);
    end
    check("z_busy", busy_z, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
